// File: rtl/pe_injection_queue.sv
// rtl/pe_injection_queue.sv - PE-to-router injection FIFO with destination filtering and statistics
module pe_injection_queue #(
  parameter int X           = 4,
  parameter int Y           = 4,
  parameter int dest_x      = 2,
  parameter int dest_y      = 2,
  parameter int source_x    = 8,
  parameter int source_y    = 8,
  parameter int data_width  = 240,
  parameter int total_width = dest_x + dest_y + source_x + source_y + data_width,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [total_width-1:0]   i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [total_width-1:0]   o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [31:0]              o_inj_count,
  output logic [15:0]              o_drop_count,
  output logic [31:0]              o_stall_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [total_width-1:0] mem [DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [CW-1:0]          count;
  logic [31:0]            inj_count;
  logic [15:0]            drop_count;
  logic [31:0]            stall_count;

  logic accept;
  logic dest_ok;
  logic push;
  logic pop;

  assign o_full   = (count == CW'(DEPTH));
  assign o_empty  = (count == '0);
  assign o_ready  = !o_full;
  assign o_valid  = !o_empty;
  assign o_data   = mem[rd_ptr];
  assign o_count  = count;

  assign o_inj_count   = inj_count;
  assign o_drop_count  = drop_count;
  assign o_stall_count = stall_count;

  // Out-of-mesh packets still complete the handshake so the PE never stalls on them.
  assign dest_ok = (32'(i_data[dest_x-1:0]) < X) &&
                   (32'(i_data[dest_x+dest_y-1:dest_x]) < Y);
  assign accept  = i_valid && o_ready;
  assign push    = accept && dest_ok;
  assign pop     = o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inj_count   <= '0;
      drop_count  <= '0;
      stall_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        inj_count <= inj_count + 32'd1;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (accept && !dest_ok && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (o_valid && !i_ready) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pe_injection_queue.sv
// tb/tb_pe_injection_queue.sv - directed self-checking bench for pe_injection_queue
module tb_pe_injection_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic [259:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic [259:0] o_data;
  logic         o_valid;
  logic         i_ready;
  logic [2:0]   o_count;
  logic         o_full;
  logic         o_empty;
  logic [31:0]  o_inj_count;
  logic [15:0]  o_drop_count;
  logic [31:0]  o_stall_count;

  int passed = 0;
  int total  = 0;

  pe_injection_queue #(.X(3), .Y(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_count       (o_count),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_inj_count   (o_inj_count),
    .o_drop_count  (o_drop_count),
    .o_stall_count (o_stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [259:0] pkt(input logic [1:0] dx, input logic [1:0] dy, input int payload);
    logic [239:0] pl;
    pl = 240'(payload);
    return {pl, 8'h5A, 8'hA5, dy, dx};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", o_empty); else passed++;
    total++; if (o_full !== 1'b0) $display("FAIL reset_full got %b want 0", o_full); else passed++;
    total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid); else passed++;
    total++; if (o_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_ready); else passed++;
    total++; if (o_count !== 3'd0) $display("FAIL reset_count got %0d want 0", o_count); else passed++;
    total++; if ({o_inj_count, o_drop_count, o_stall_count} !== 80'd0)
      $display("FAIL reset_counters got inj=%0d drop=%0d stall=%0d want 0", o_inj_count, o_drop_count, o_stall_count);
    else passed++;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 4; k++) begin
      i_data = pkt(2'd1, 2'd1, k); i_valid = 1'b1;
      step();
    end
    i_valid = 1'b0;
    total++; if (o_count !== 3'd4) $display("FAIL fill_count got %0d want 4", o_count); else passed++;
    total++; if (o_full !== 1'b1) $display("FAIL fill_full got %b want 1", o_full); else passed++;
    total++; if (o_ready !== 1'b0) $display("FAIL fill_ready got %b want 0", o_ready); else passed++;
    total++; if (o_data !== pkt(2'd1, 2'd1, 1)) $display("FAIL fill_head got %0d want 1", o_data[259:20]); else passed++;
    total++; if (o_stall_count !== 32'd3) $display("FAIL fill_stall got %0d want 3", o_stall_count); else passed++;
    step();
    total++; if (o_stall_count !== 32'd4) $display("FAIL fill_stall_idle got %0d want 4", o_stall_count); else passed++;
  endtask

  task automatic test_drain();
    i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++; if (o_data !== pkt(2'd1, 2'd1, k)) $display("FAIL drain_order_%0d got %0d want %0d", k, o_data[259:20], k); else passed++;
      step();
    end
    i_ready = 1'b0;
    total++; if (o_inj_count !== 32'd4) $display("FAIL drain_inj got %0d want 4", o_inj_count); else passed++;
    total++; if (o_empty !== 1'b1) $display("FAIL drain_empty got %b want 1", o_empty); else passed++;
    total++; if (o_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", o_valid); else passed++;
    total++; if (o_stall_count !== 32'd4) $display("FAIL drain_stall got %0d want 4", o_stall_count); else passed++;
  endtask

  task automatic test_back_to_back();
    int bad_cnt = 0;
    int bad_ord = 0;
    do_reset();
    i_valid = 1'b1; i_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      i_data = pkt(2'd2, 2'd0, 100 + k);
      step();
      if (o_count !== 3'd1) bad_cnt++;
      if (o_data !== pkt(2'd2, 2'd0, 100 + k)) bad_ord++;
    end
    i_valid = 1'b0;
    total++; if (bad_cnt != 0) $display("FAIL b2b_count got %0d bad cycles want 0", bad_cnt); else passed++;
    total++; if (bad_ord != 0) $display("FAIL b2b_order got %0d bad cycles want 0", bad_ord); else passed++;
    total++; if (o_inj_count !== 32'd19) $display("FAIL b2b_inj got %0d want 19", o_inj_count); else passed++;
    step();
    total++; if (o_empty !== 1'b1 || o_inj_count !== 32'd20)
      $display("FAIL b2b_tail got empty=%b inj=%0d want empty=1 inj=20", o_empty, o_inj_count);
    else passed++;
    total++; if (o_stall_count !== 32'd0) $display("FAIL b2b_stall got %0d want 0", o_stall_count); else passed++;
    i_ready = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    i_data = pkt(2'd3, 2'd0, 7); i_valid = 1'b1;
    step();
    total++; if (o_drop_count !== 16'd1 || o_count !== 3'd0 || o_ready !== 1'b1)
      $display("FAIL drop_x got drop=%0d count=%0d ready=%b want 1 0 1", o_drop_count, o_count, o_ready);
    else passed++;
    i_data = pkt(2'd0, 2'd3, 8);
    step();
    total++; if (o_drop_count !== 16'd2 || o_count !== 3'd0 || o_empty !== 1'b1)
      $display("FAIL drop_y got drop=%0d count=%0d empty=%b want 2 0 1", o_drop_count, o_count, o_empty);
    else passed++;
    i_data = pkt(2'd2, 2'd2, 9);
    step();
    i_valid = 1'b0;
    total++; if (o_drop_count !== 16'd2 || o_count !== 3'd1 || o_data !== pkt(2'd2, 2'd2, 9))
      $display("FAIL drop_edge got drop=%0d count=%0d payload=%0d want 2 1 9", o_drop_count, o_count, o_data[259:20]);
    else passed++;
  endtask

  task automatic test_full_pop_push();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      i_data = pkt(2'd0, 2'd1, k); i_valid = 1'b1;
      step();
    end
    i_data = pkt(2'd0, 2'd1, 5); i_ready = 1'b1;
    total++; if (o_ready !== 1'b0) $display("FAIL fpp_ready got %b want 0", o_ready); else passed++;
    step();
    total++; if (o_count !== 3'd3 || o_data !== pkt(2'd0, 2'd1, 2))
      $display("FAIL fpp_refused got count=%0d payload=%0d want 3 2", o_count, o_data[259:20]);
    else passed++;
    i_ready = 1'b0;
    step();
    i_valid = 1'b0;
    total++; if (o_count !== 3'd4 || o_full !== 1'b1)
      $display("FAIL fpp_retry got count=%0d full=%b want 4 1", o_count, o_full);
    else passed++;
    i_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      total++; if (o_data !== pkt(2'd0, 2'd1, k)) $display("FAIL fpp_order_%0d got %0d want %0d", k, o_data[259:20], k); else passed++;
      step();
    end
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      i_data = pkt(2'd1, 2'd2, 40 + k); i_valid = 1'b1;
      step();
    end
    i_data = pkt(2'd3, 2'd3, 44);
    step();
    i_valid = 1'b0;
    total++; if (o_count !== 3'd3 || o_drop_count !== 16'd1 || o_stall_count !== 32'd3)
      $display("FAIL mid_pre got count=%0d drop=%0d stall=%0d want 3 1 3", o_count, o_drop_count, o_stall_count);
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (o_valid !== 1'b0 || o_count !== 3'd0) $display("FAIL mid_state got valid=%b count=%0d want 0 0", o_valid, o_count); else passed++;
    total++; if ({o_inj_count, o_drop_count, o_stall_count} !== 80'd0)
      $display("FAIL mid_counters got inj=%0d drop=%0d stall=%0d want 0", o_inj_count, o_drop_count, o_stall_count);
    else passed++;
    i_data = pkt(2'd0, 2'd0, 9); i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    total++; if (o_valid !== 1'b1 || o_data !== pkt(2'd0, 2'd0, 9) || o_count !== 3'd1)
      $display("FAIL mid_push got valid=%b payload=%0d count=%0d want 1 9 1", o_valid, o_data[259:20], o_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_drop();
    test_full_pop_push();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
